// File: rtl/ahb3lite_wbuf_slave_if.sv
// AHB-Lite write-buffer slave bus bundle.
// Carries the AHB-Lite slave-side signals (HSEL, HADDR, HWRITE, HSIZE, HTRANS,
// HREADY, HWDATA in; HREADYOUT, HRESP out) and the memory write port
// (mem_WR_addr, HWDATA_toMem, mem_write_flag out; mem_ready in).
// mem_byte_en exists only when AHB_WBUF_BYTE_STROBE_EN is defined.
// Modports: slave (the buffer), master (bus master + memory model).
interface ahb3lite_wbuf_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [1:0]        HTRANS;
  logic              HREADY;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic [ADDR_W-1:0] mem_WR_addr;
  logic [DATA_W-1:0] HWDATA_toMem;
  logic              mem_write_flag;
  logic              mem_ready;
`ifdef AHB_WBUF_BYTE_STROBE_EN
  logic [3:0]        mem_byte_en;

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA, mem_ready,
    output HREADYOUT, HRESP, mem_WR_addr, HWDATA_toMem, mem_write_flag, mem_byte_en
  );
  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA, mem_ready,
    input  HREADYOUT, HRESP, mem_WR_addr, HWDATA_toMem, mem_write_flag, mem_byte_en
  );
`else
  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA, mem_ready,
    output HREADYOUT, HRESP, mem_WR_addr, HWDATA_toMem, mem_write_flag
  );
  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA, mem_ready,
    input  HREADYOUT, HRESP, mem_WR_addr, HWDATA_toMem, mem_write_flag
  );
`endif
endinterface

// File: rtl/ahb3lite_wbuf_slave.sv
// AHB-Lite write-buffer slave.
// Accepted writes are queued in a DEPTH-entry FIFO and complete with zero wait
// states unless the FIFO is full; the FIFO drains to a simple memory write
// port. Reads and unsupported writes get a two-cycle ERROR response.
// Ports:
//   HCLK   - clock, rising edge
//   HRESET - asynchronous active-high reset
//   bus    - ahb3lite_wbuf_slave_if.slave (AHB-Lite slave + memory write port)
// Optional feature: AHB_WBUF_BYTE_STROBE_EN enables byte/halfword writes and
// the mem_byte_en output; without it only aligned word writes are accepted.
module ahb3lite_wbuf_slave #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb3lite_wbuf_slave_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t state, state_nxt, accept_state;

  logic              accept, take, write_ok;
  logic              hreadyout, hresp;
  logic              push, pop, full, empty;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
`ifdef AHB_WBUF_BYTE_STROBE_EN
  logic [2:0]        size_q;
  logic [3:0]        be_dec;
  logic [3:0]        fifo_be [DEPTH];
`endif

  assign accept = bus.HSEL & bus.HREADY &
                  ((bus.HTRANS == 2'b10) | (bus.HTRANS == 2'b11));
  // Address phase is only taken while this slave is not stalling the bus.
  assign take   = accept & hreadyout;

  // Write legality is decided in the address phase from live HADDR/HSIZE.
  always_comb begin
    write_ok = 1'b0;
`ifdef AHB_WBUF_BYTE_STROBE_EN
    case (bus.HSIZE)
      3'b000:  write_ok = bus.HWRITE;
      3'b001:  write_ok = bus.HWRITE & ~bus.HADDR[0];
      3'b010:  write_ok = bus.HWRITE & (bus.HADDR[1:0] == 2'b00);
      default: write_ok = 1'b0;
    endcase
`else
    write_ok = bus.HWRITE & (bus.HSIZE == 3'b010) & (bus.HADDR[1:0] == 2'b00);
`endif
  end

  assign accept_state = write_ok ? S_DATA : S_ERR1;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = ~empty & bus.mem_ready;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (take) state_nxt = accept_state;
      end
      S_DATA: begin
        hreadyout = ~full;
        if (!full) begin
          push      = 1'b1;
          state_nxt = take ? accept_state : S_IDLE;
        end
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        hresp     = 1'b1;
        state_nxt = take ? accept_state : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q <= '0;
`ifdef AHB_WBUF_BYTE_STROBE_EN
      size_q <= '0;
`endif
    end else if (take) begin
      addr_q <= bus.HADDR;
`ifdef AHB_WBUF_BYTE_STROBE_EN
      size_q <= bus.HSIZE;
`endif
    end
  end

`ifdef AHB_WBUF_BYTE_STROBE_EN
  always_comb begin
    be_dec = 4'b1111;
    case (size_q)
      3'b000:  be_dec = 4'b0001 << addr_q[1:0];
      3'b001:  be_dec = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be_dec = 4'b1111;
    endcase
  end
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
`ifdef AHB_WBUF_BYTE_STROBE_EN
        fifo_be[i]   <= '0;
`endif
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= addr_q;
        fifo_data[wr_ptr] <= bus.HWDATA;
`ifdef AHB_WBUF_BYTE_STROBE_EN
        fifo_be[wr_ptr]   <= be_dec;
`endif
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.HREADYOUT      = hreadyout;
  assign bus.HRESP          = hresp;
  assign bus.mem_write_flag = ~empty;
  assign bus.mem_WR_addr    = fifo_addr[rd_ptr];
  assign bus.HWDATA_toMem   = fifo_data[rd_ptr];
`ifdef AHB_WBUF_BYTE_STROBE_EN
  assign bus.mem_byte_en    = fifo_be[rd_ptr];
`endif
endmodule

// File: tb/tb_ahb3lite_wbuf_slave.sv
// Bench for ahb3lite_wbuf_slave: pipelined AHB-Lite driver with per-beat
// expected responses, and a memory-side scoreboard checked by a monitor.
module tb_ahb3lite_wbuf_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb3lite_wbuf_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb3lite_wbuf_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .HCLK(clk), .HRESET(rst), .bus(bus)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;     // expected ERROR response
    int          wait_exp; // expected wait states, -1 = at least one
    logic        queued;  // expected to reach the memory port
    logic [3:0]  be;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  beat_t seq[$];
  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t bt(input logic sel, input logic [1:0] tr, input logic wr,
                               input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                               input logic err, input int w, input logic q, input logic [3:0] be);
    beat_t b;
    b.sel = sel; b.trans = tr; b.wr = wr; b.size = sz; b.addr = a; b.data = d;
    b.err = err; b.wait_exp = w; b.queued = q; b.be = be;
    return b;
  endfunction

  // Shorthands: aligned OK word write, and an erroring transfer.
  function automatic beat_t wword(input logic [31:0] a, input logic [31:0] d);
    return bt(1'b1, 2'b10, 1'b1, 3'b010, a, d, 1'b0, 0, 1'b1, 4'b1111);
  endfunction
  function automatic beat_t werr(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    return bt(1'b1, 2'b10, wr, sz, a, 32'h0, 1'b1, 1, 1'b0, 4'b0000);
  endfunction

  // Memory-side monitor: every accepted pop must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.mem_write_flag && bus.mem_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_mem_write", {32'h0, bus.mem_WR_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mem_addr", {32'h0, bus.mem_WR_addr}, {32'h0, e.addr});
        chk("mem_data", {32'h0, bus.HWDATA_toMem}, {32'h0, e.data});
`ifdef AHB_WBUF_BYTE_STROBE_EN
        chk("mem_be", {60'h0, bus.mem_byte_en}, {60'h0, e.be});
`endif
      end
    end
  end

  task automatic drive_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010; bus.HADDR = '0;
  endtask

  task automatic run_seq();
    int unsigned ai = 0;
    bit          dp_act = 0;
    beat_t       dp;
    int          waits = 0;
    logic        first_resp = 1'b0;
    int          guard = 0;
    logic        rdy;
    while ((ai < seq.size() || dp_act) && guard < 300) begin
      guard++;
      if (ai < seq.size()) begin
        bus.HSEL = seq[ai].sel; bus.HTRANS = seq[ai].trans; bus.HWRITE = seq[ai].wr;
        bus.HSIZE = seq[ai].size; bus.HADDR = seq[ai].addr;
      end else begin
        drive_idle();
      end
      bus.HWDATA = dp_act ? dp.data : 32'h0;
      @(negedge clk);
      rdy = bus.HREADYOUT;
      if (dp_act) begin
        if (rdy) begin
          chk("hresp", {63'h0, bus.HRESP}, {63'h0, dp.err});
          if (dp.wait_exp < 0) chk("waited", {63'h0, waits >= 1}, 64'h1);
          else                 chk("waits", 64'(waits), 64'(dp.wait_exp));
          if (dp.err) chk("err_first_cycle_hresp", {63'h0, first_resp}, 64'h1);
        end else begin
          if (waits == 0) first_resp = bus.HRESP;
          waits++;
        end
      end
      @(posedge clk);
      if (rdy) begin
        if (ai < seq.size()) begin
          if (seq[ai].queued) sb.push_back('{seq[ai].addr, seq[ai].data, seq[ai].be});
          dp = seq[ai]; dp_act = 1; ai++;
        end else begin
          dp_act = 0;
        end
        waits = 0;
      end
      #1;
    end
    if (guard >= 300) chk("run_seq_timeout", 64'h1, 64'h0);
    drive_idle();
    seq.delete();
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sb.size() != 0 || bus.mem_write_flag) && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("drain_done", {63'h0, bus.mem_write_flag}, 64'h0);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    bus.HWDATA = '0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hreadyout", {63'h0, bus.HREADYOUT}, 64'h1);
    chk("rst_hresp", {63'h0, bus.HRESP}, 64'h0);
    chk("rst_flag", {63'h0, bus.mem_write_flag}, 64'h0);
    chk("rst_addr", {32'h0, bus.mem_WR_addr}, 64'h0);
    chk("rst_data", {32'h0, bus.HWDATA_toMem}, 64'h0);
`ifdef AHB_WBUF_BYTE_STROBE_EN
    chk("rst_be", {60'h0, bus.mem_byte_en}, 64'h0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write, memory ready
    seq.push_back(wword(32'h100, 32'hDEADBEEF));
    run_seq();
    wait_drain();

    // Six writes into a stalled memory; 5th must wait until drain starts
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      beat_t b;
      b = wword(32'(i * 4), 32'hA000_0000 + 32'(i));
      if (i == 4) b.wait_exp = -1;
      seq.push_back(b);
    end
    fork
      run_seq();
      begin repeat (10) @(posedge clk); #1; bus.mem_ready = 1'b1; end
    join
    wait_drain();

    // Read error with one entry held in the FIFO
    bus.mem_ready = 1'b0;
    seq.push_back(wword(32'h180, 32'h1111_2222));
    seq.push_back(werr(1'b0, 3'b010, 32'h200));
    seq.push_back(wword(32'h184, 32'h3333_4444));
    run_seq();
    bus.mem_ready = 1'b1;
    wait_drain();

    // HSEL / BUSY / IDLE filtering
    seq.push_back(wword(32'h300, 32'h0000_0300));
    seq.push_back(bt(1'b1, 2'b01, 1'b1, 3'b010, 32'h304, 32'h304, 1'b0, 0, 1'b0, 4'b0));
    seq.push_back(bt(1'b0, 2'b10, 1'b1, 3'b010, 32'h308, 32'h308, 1'b0, 0, 1'b0, 4'b0));
    seq.push_back(bt(1'b1, 2'b00, 1'b1, 3'b010, 32'h30C, 32'h30C, 1'b0, 0, 1'b0, 4'b0));
    seq.push_back(bt(1'b1, 2'b11, 1'b1, 3'b010, 32'h310, 32'h0000_0310, 1'b0, 0, 1'b1, 4'b1111));
    seq.push_back(bt(1'b0, 2'b11, 1'b1, 3'b010, 32'h314, 32'h314, 1'b0, 0, 1'b0, 4'b0));
    run_seq();
    wait_drain();

    // Size / alignment handling
`ifdef AHB_WBUF_BYTE_STROBE_EN
    seq.push_back(bt(1'b1, 2'b10, 1'b1, 3'b000, 32'h103, 32'h5500_0000, 1'b0, 0, 1'b1, 4'b1000));
    seq.push_back(werr(1'b1, 3'b001, 32'h101));
    seq.push_back(bt(1'b1, 2'b10, 1'b1, 3'b001, 32'h102, 32'h6666_0000, 1'b0, 0, 1'b1, 4'b1100));
    seq.push_back(bt(1'b1, 2'b10, 1'b1, 3'b000, 32'h100, 32'h0000_0077, 1'b0, 0, 1'b1, 4'b0001));
    seq.push_back(werr(1'b1, 3'b010, 32'h102));
    seq.push_back(werr(1'b1, 3'b011, 32'h108));
`else
    seq.push_back(werr(1'b1, 3'b000, 32'h103));
    seq.push_back(werr(1'b1, 3'b001, 32'h100));
    seq.push_back(werr(1'b1, 3'b010, 32'h102));
    seq.push_back(werr(1'b1, 3'b011, 32'h108));
`endif
    seq.push_back(wword(32'h10C, 32'hCAFE_F00D));
    run_seq();
    wait_drain();

    // Reset with 3 entries queued and a write in its data phase
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) seq.push_back(wword(32'h400 + 32'(i * 4), 32'hBB00 + 32'(i)));
    run_seq();
    chk("pre_reset_flag", {63'h0, bus.mem_write_flag}, 64'h1);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HSIZE = 3'b010;
    bus.HADDR = 32'h40C;
    @(posedge clk); #1;
    drive_idle();
    bus.HWDATA = 32'hBB03;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_flag", {63'h0, bus.mem_write_flag}, 64'h0);
    chk("async_rst_hreadyout", {63'h0, bus.HREADYOUT}, 64'h1);
    chk("async_rst_hresp", {63'h0, bus.HRESP}, 64'h0);
    chk("async_rst_addr", {32'h0, bus.mem_WR_addr}, 64'h0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_no_stale", {63'h0, bus.mem_write_flag}, 64'h0);

    // Recovery after reset
    seq.push_back(wword(32'h500, 32'h1234_5678));
    run_seq();
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb3lite_wbuf_slave.md
# ahb3lite_wbuf_slave

AHB-Lite write-buffer slave that terminates transfers issued by the CPU/DMA master and converts them into a simple memory write port. Accepted write transfers are queued in a small FIFO so the bus completes with zero wait states while memory drains at its own pace. Read transfers and unsupported writes get a two-cycle ERROR response. Upstream is the AHB-Lite master; downstream is the memory write port (`mem_WR_addr` / `mem_write_flag` / `HWDATA_toMem`).

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; must be 32.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `HCLK` in 1: the only clock; all state updates on its rising edge.
- `HRESET` in 1: asynchronous, active-high reset.
- `HSEL` in 1: slave select.
- `HADDR` in `ADDR_W`: address-phase address.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: transfer size.
- `HTRANS` in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HREADY` in 1: bus-level ready; address phase is sampled only when 1.
- `HWDATA` in `DATA_W`: data-phase write data.
- `HREADYOUT` out 1: slave ready.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.
- `mem_WR_addr` out `ADDR_W`: head-entry address.
- `HWDATA_toMem` out `DATA_W`: head-entry data.
- `mem_write_flag` out 1: head entry valid (write request).
- `mem_ready` in 1: memory accepts the head entry this cycle.
- `mem_byte_en` out 4: only when `AHB_WBUF_BYTE_STROBE_EN` is defined.

## Operation
- **Address phase.** A transfer is accepted when `HSEL & HREADY & HTRANS[1]` (NONSEQ or SEQ). The slave registers `HADDR`, `HWRITE`, `HSIZE` and a pending flag.
- **IDLE / BUSY / unselected.** No pending flag is set. Any such cycle that falls in a data phase completes OKAY with zero wait states.
- **FSM states:**
  - `S_IDLE`: no data phase pending.
  - `S_DATA`: write data phase.
  - `S_ERR1`: first ERROR cycle, `HREADYOUT`=0, `HRESP`=1.
  - `S_ERR2`: second ERROR cycle, `HREADYOUT`=1, `HRESP`=1.
- **FSM transitions:**
  - An accepted write goes to `S_DATA`.
  - An accepted read or unsupported write goes to `S_ERR1`, then `S_ERR2`.
  - From `S_ERR2`, go to `S_IDLE`, or to the next state if a new transfer is accepted in that cycle.
- **Write data phase (`S_DATA`).**
  - `HREADYOUT` = !full.
  - While `HREADYOUT`=1, the edge pushes {registered addr, `HWDATA`, registered size}.
  - While full, `HREADYOUT`=0; the slave waits and pushes on the first cycle that full is clear.
- **FIFO.**
  - Read/write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - Count is `$clog2(DEPTH)+1` bits; full when count == `DEPTH`, empty when count == 0.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Pop when `mem_write_flag & mem_ready`.
- **Drain.**
  - `mem_write_flag` = !empty.
  - `mem_WR_addr` and `HWDATA_toMem` are the head-entry register values.
  - The head entry is held stable until popped.
- **Reset.** Asserting `HRESET` at any time empties the FIFO, discards any pending or in-flight transfer, and forces `S_IDLE`.
- **Reset values:**
  - `HREADYOUT`=1, `HRESP`=0.
  - `mem_write_flag`=0, `mem_WR_addr`=0, `HWDATA_toMem`=0.
  - `mem_byte_en`=0.

## Timing
- Write data phase completes on edge N with zero wait states if not full.
- The entry appears at the memory outputs after edge N (visible in cycle N+1).
- Full buffer: 1 wait state minimum. The cycle `mem_ready` pops, `HREADYOUT` stays 0; it rises the following cycle (no combinational path from `mem_ready` to `HREADYOUT`).
- Throughput is 1 write/cycle when memory drains 1/cycle.
- ERROR costs exactly 2 data-phase cycles.
- `HRESP` and `HREADYOUT` are driven from registered state only.

## Configuration
- **Macro:** `AHB_WBUF_BYTE_STROBE_EN`.
- **Defined:**
  - Byte (`HSIZE`=000), halfword (001) and word (010) writes are accepted.
  - `mem_byte_en` is decoded from size and `HADDR[1:0]`: byte → one-hot lane; halfword → 0011 or 1100; word → 1111.
  - A halfword with `HADDR[0]`=1, a word with `HADDR[1:0]`≠0, or `HSIZE`>010 produces ERROR.
- **Undefined:**
  - The `mem_byte_en` port and its FIFO field are absent.
  - Only word writes with `HADDR[1:0]`=00 are accepted; every other write produces ERROR.

## Test plan
- Reset, then one NONSEQ word write of addr 0x100, data 0xDEADBEEF with `mem_ready`=1 → `HREADYOUT`=1 throughout; next cycle `mem_write_flag`=1, `mem_WR_addr`=0x100, `HWDATA_toMem`=0xDEADBEEF for exactly one cycle.
- `mem_ready`=0, 6 back-to-back writes at 0x0..0x14, `DEPTH`=4 → writes 1–4 zero-wait; 5th data phase sees `HREADYOUT`=0. Raise `mem_ready` → entries drain in order 0x0, 0x4, …; all 6 delivered, none lost or duplicated.
- Read transfer at 0x200 → `HREADYOUT`=0/`HRESP`=1, then `HREADYOUT`=1/`HRESP`=1, then OKAY; FIFO count unchanged.
- Write, BUSY, IDLE, write sequence with `HSEL` toggling → only the HSEL=1 NONSEQ/SEQ writes are queued; BUSY/IDLE data phases complete OKAY.
- Assert `HRESET` with 3 entries queued and a write in data phase → `mem_write_flag`=0 immediately; after release no stale entry appears.
- Byte-strobe config: byte write to 0x103 → `mem_byte_en`=1000; halfword to 0x101 → ERROR. Without the macro, the byte write → ERROR.
